// File: rtl/mem_responder.sv
// Byte-wide memory responder with programmable wait states and address-window decode.
// Each access follows IDLE -> WAIT -> DONE -> RELEASE, and a rejected request pulses err.
module mem_responder #(
    parameter int          WAIT_CYCLES = 2,
    parameter logic [15:0] BASE_ADDR   = 16'h0000,
    parameter int          DEPTH       = 256
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] addr_bus,
    input  logic [7:0]  wdata,
    output logic [7:0]  rdata,
    input  logic        mem_ce,
    input  logic        mem_r,
    input  logic        mem_w,
    input  logic        mem_oe,
    output logic        ready,
    output logic        err
);
    localparam int         AW        = $clog2(DEPTH);
    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_WAIT    = 2'd1;
    localparam logic [1:0] S_DONE    = 2'd2;
    localparam logic [1:0] S_RELEASE = 2'd3;

    logic [1:0]    state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic          ready_q, ready_d;
    logic          err_q, err_d;
    logic [7:0]    rdata_q;
    logic [AW-1:0] idx_q, idx_d;
    logic [7:0]    wdata_q, wdata_d;
    logic          wr_q, wr_d;
    logic [7:0]    mem [DEPTH];

    logic [15:0]   offset;
    logic          in_range;
    logic          req;
    logic          conflict;
    logic          commit;
    logic          commit_wr;
    logic [AW-1:0] commit_idx;
    logic [7:0]    commit_data;

    // The lower-bound test keeps the subtraction from wrapping, so offset is exact when compared.
    assign offset   = addr_bus - BASE_ADDR;
    assign in_range = (addr_bus >= BASE_ADDR) && ({1'b0, offset} < 17'(DEPTH));
    assign req      = mem_ce && (mem_r ^ mem_w);
    assign conflict = mem_ce && mem_r && mem_w;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        wdata_d     = wdata_q;
        wr_d        = wr_q;
        err_d       = 1'b0;
        commit      = 1'b0;
        commit_wr   = wr_q;
        commit_idx  = idx_q;
        commit_data = wdata_q;
        case (state_q)
            S_IDLE: begin
                if (conflict || (req && !in_range)) begin
                    err_d   = 1'b1;
                    state_d = S_RELEASE;
                end else if (req) begin
                    idx_d   = offset[AW-1:0];
                    wdata_d = wdata;
                    wr_d    = mem_w;
                    if (WAIT_CYCLES == 0) begin
                        // With no wait states the capture edge is also the commit edge.
                        state_d     = S_DONE;
                        commit      = 1'b1;
                        commit_wr   = mem_w;
                        commit_idx  = offset[AW-1:0];
                        commit_data = wdata;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = WAIT_LOAD;
                    end
                end
            end
            S_WAIT: begin
                if (!mem_ce) begin
                    state_d = S_IDLE;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        state_d = S_DONE;
                        commit  = 1'b1;
                    end
                end
            end
            S_DONE: state_d = S_RELEASE;
            default: begin
                if (!mem_ce) state_d = S_IDLE;
            end
        endcase
        ready_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= 8'h00;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ready_q <= ready_d;
            err_q   <= err_d;
            if (commit && !commit_wr) rdata_q <= mem[commit_idx];
        end
    end

    always_ff @(posedge clk) begin
        idx_q   <= idx_d;
        wdata_q <= wdata_d;
        wr_q    <= wr_d;
    end

    // Storage is never reset; rst_n gates the write so a reset edge cannot commit.
    always_ff @(posedge clk) begin
        if (rst_n && commit && commit_wr) mem[commit_idx] <= commit_data;
    end

    assign rdata = mem_oe ? rdata_q : 8'h00;
    assign ready = ready_q;
    assign err   = err_q;
endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 SHALL have parameter WAIT_CYCLES, default 2, giving the number of wait-state cycles per access (0..15).
REQ-002 SHALL have parameter BASE_ADDR, default 16'h0000, giving the first address decoded by the block.
REQ-003 SHALL have parameter DEPTH, default 256, giving the number of bytes of storage (power of two, 2..4096).
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-006 SHALL have port addr_bus, input, 16 bits: byte address from the CPU.
REQ-007 SHALL have port wdata, input, 8 bits: write data from the CPU.
REQ-008 SHALL have port rdata, output, 8 bits: read data to the CPU.
REQ-009 SHALL have port mem_ce, input, 1 bit: chip enable (request valid).
REQ-010 SHALL have ports mem_r and mem_w, input, 1 bit each: the read strobe and the write strobe.
REQ-011 SHALL have port mem_oe, input, 1 bit: output enable; rdata is driven 8'h00 when this is low.
REQ-012 SHALL have port ready, output, 1 bit: one-cycle pulse marking access completion.
REQ-013 SHALL have port err, output, 1 bit: one-cycle pulse marking a rejected request.

Function
REQ-014 SHALL implement FSM states IDLE, WAIT, DONE and RELEASE.
REQ-015 SHALL, in IDLE, treat mem_ce=1 with exactly one of mem_r/mem_w high as a request, and capture addr_bus, wdata and direction at that edge.
REQ-016 SHALL, when a captured address lies outside BASE_ADDR..BASE_ADDR+DEPTH-1 (no wrap past 16'hFFFF), pulse err for 1 cycle, perform no access and go to RELEASE.
REQ-017 SHALL, when mem_ce=1 with mem_r=mem_w=1, pulse err for 1 cycle, perform no access and go to RELEASE.
REQ-018 SHALL go from IDLE to WAIT for a valid request, loading a counter with WAIT_CYCLES; if WAIT_CYCLES=0 it SHALL go directly to DONE.
REQ-019 SHALL decrement the counter every cycle in WAIT and go to DONE on the edge where the counter reaches 0.
REQ-020 SHALL abort to IDLE, with no write and no ready, if mem_ce is sampled low in WAIT.
REQ-021 SHALL, on the edge entering DONE, commit the write to storage at index (addr-BASE_ADDR), or register the read byte.
REQ-022 SHALL assert ready only while in DONE, giving ready exactly WAIT_CYCLES+1 cycles after the sampling edge.
REQ-023 SHALL go from DONE to RELEASE unconditionally.
REQ-024 SHALL stay in RELEASE while mem_ce=1 and go to IDLE when mem_ce=0, so a held strobe never causes a second access.
REQ-025 SHALL hold rdata at the last read byte until the next read completes; writes SHALL NOT alter rdata.
REQ-026 SHALL make a read issued after a write to the same address return the new data.
REQ-027 SHALL ignore changes to addr_bus, wdata, mem_r and mem_w after capture.

Reset
REQ-028 SHALL, while rst_n=0, force state=IDLE, counter=0, ready=0, err=0 and the rdata register to 8'h00, independent of clk.
REQ-029 SHALL leave storage contents unchanged by reset.
REQ-030 SHALL discard an access interrupted by reset in WAIT or DONE (before the commit edge), with no write.
REQ-031 SHALL accept a new request on the first rising edge after rst_n rises.

Verification
REQ-032 SHALL cover: WAIT_CYCLES=2, write 8'hA5 to 16'h0010, then read 16'h0010 with mem_oe=1 -> ready 3 cycles after each request; rdata=8'hA5.
REQ-033 SHALL cover: WAIT_CYCLES=0, read 16'h0000 -> ready on the next cycle; strobes held 5 cycles -> exactly one ready pulse.
REQ-034 SHALL cover: read 16'h0100 (DEPTH=256) and mem_r=mem_w=1 at 16'h0001 -> err 1-cycle pulse each; ready stays 0; storage unchanged.
REQ-035 SHALL cover: write 8'h3C to 16'h0020, drop mem_ce during WAIT -> no ready; subsequent read of 16'h0020 returns the old value.
REQ-036 SHALL cover: rst_n low mid-WAIT of a write of 8'hFF to 16'h0005 -> outputs 0 immediately; 16'h0005 keeps its old value; request after reset completes normally.
REQ-037 SHALL cover: mem_oe=0 during a completed read -> rdata=8'h00; raising mem_oe -> rdata shows the held byte.
